// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the CPU clock generator.
package clkgen_pkg;

    typedef enum logic [2:0] {
        HALT      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_HI   = 3'd3,
        STEP_LO   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_STEP = 2'd2,
        MODE_RSVD = 2'd3
    } mode_t;

    // Half period in board-clock cycles for a given rate select.
    // Shifts of 32 or more bits yield 0, which is clamped to 1.
    function automatic logic [31:0] half_period(input logic [31:0] hz, input logic [31:0] sel);
        logic [31:0] h;
        h = hz >> (sel + 32'd1);
        return (h == 32'd0) ? 32'd1 : h;
    endfunction

endpackage

// File: rtl/cpu_clock_gen_debounce.sv
// Step-button conditioner: 2-flop synchroniser, stability filter and press-edge pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic PHYSICAL_CLOCK,
    input  logic PHYSICAL_RESET,
    input  logic BUTTON,
    output logic LEVEL,
    output logic PRESS
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;
    logic             differ_s;
    logic             accept_s;

    // The filtered level flips once enough consecutive samples disagree with it.
    assign differ_s = (sync2_q != level_q);
    assign accept_s = differ_s && (cnt_q == CNT_LAST);

    // Bring the asynchronous button into the board-clock domain.
    always_ff @(posedge PHYSICAL_CLOCK or negedge PHYSICAL_RESET) begin
        if (!PHYSICAL_RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= BUTTON;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing samples, accept the new level and flag a 0->1 acceptance.
    always_ff @(posedge PHYSICAL_CLOCK or negedge PHYSICAL_RESET) begin
        if (!PHYSICAL_RESET) begin
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            press_q <= accept_s & sync2_q;
            if (!differ_s) begin
                cnt_q <= '0;
            end else if (accept_s) begin
                cnt_q   <= '0;
                level_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign LEVEL = level_q;
    assign PRESS = press_q;

endmodule

// File: rtl/cpu_clock_gen.sv
// Slow CPU clock generator with HALT / RUN / single-STEP modes and a rise counter.
module cpu_clock_gen
    import clkgen_pkg::*;
#(
    parameter int CLOCK_HZ        = 100_000_000,
    parameter int SEL_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   PHYSICAL_CLOCK,
    input  logic                   PHYSICAL_RESET,
    input  logic [SEL_WIDTH-1:0]   SEL,
    input  logic [1:0]             MODE,
    input  logic                   BUTTON,
    output logic                   CLOCK,
    output logic                   CLOCK_RISE,
    output logic [COUNT_WIDTH-1:0] CYCLE_COUNT,
    output logic                   RUNNING
);

    state_t                 state_q, state_d;
    logic                   clock_q, clock_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            h_q, h_d;
    logic                   rise_q;
    logic                   running_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   start_s;
    logic                   last_s;
    logic                   level_s;
    logic                   press_raw_s;
    logic                   press_s;
    mode_t                  mode_s;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .PHYSICAL_CLOCK(PHYSICAL_CLOCK),
        .PHYSICAL_RESET(PHYSICAL_RESET),
        .BUTTON        (BUTTON),
        .LEVEL         (level_s),
        .PRESS         (press_raw_s)
    );

    // A press pulse is only ever raised together with a high debounced level.
    assign press_s = press_raw_s & level_s;
    assign mode_s  = mode_t'(MODE);
    assign last_s  = (cnt_q == (h_q - 32'd1));

    // Next-state logic: phase timing, mode handling and period starts.
    always_comb begin
        state_d = state_q;
        clock_d = clock_q;
        cnt_d   = cnt_q;
        h_d     = h_q;
        start_s = 1'b0;
        case (state_q)
            HALT: begin
                if (mode_s == MODE_RUN) begin
                    state_d = RUN;
                    start_s = 1'b1;
                end else if (mode_s == MODE_STEP) begin
                    state_d = STEP_WAIT;
                end else begin
                    state_d = HALT;
                end
            end
            RUN: begin
                if (!last_s) begin
                    cnt_d = cnt_q + 32'd1;
                end else if (clock_q) begin
                    clock_d = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = 32'd0;
                    case (mode_s)
                        MODE_RUN:  start_s = 1'b1;
                        MODE_STEP: state_d = STEP_WAIT;
                        default:   state_d = HALT;
                    endcase
                end
            end
            STEP_WAIT: begin
                // A press wins over a simultaneous mode change.
                if (press_s) begin
                    state_d = STEP_HI;
                    start_s = 1'b1;
                end else if (mode_s == MODE_RUN) begin
                    state_d = RUN;
                    start_s = 1'b1;
                end else if (mode_s == MODE_STEP) begin
                    state_d = STEP_WAIT;
                end else begin
                    state_d = HALT;
                end
            end
            STEP_HI: begin
                if (last_s) begin
                    state_d = STEP_LO;
                    clock_d = 1'b0;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            STEP_LO: begin
                if (last_s) begin
                    state_d = STEP_WAIT;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = HALT;
                clock_d = 1'b0;
                cnt_d   = 32'd0;
            end
        endcase
        // Rate is sampled only when a new period begins.
        if (start_s) begin
            clock_d = 1'b1;
            cnt_d   = 32'd0;
            h_d     = half_period(32'(CLOCK_HZ), 32'(SEL));
        end else begin
            h_d = h_q;
        end
    end

    // State, generated clock, counters and registered status outputs.
    always_ff @(posedge PHYSICAL_CLOCK or negedge PHYSICAL_RESET) begin
        if (!PHYSICAL_RESET) begin
            state_q   <= HALT;
            clock_q   <= 1'b0;
            cnt_q     <= 32'd0;
            h_q       <= half_period(32'(CLOCK_HZ), 32'd0);
            rise_q    <= 1'b0;
            running_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            clock_q   <= clock_d;
            cnt_q     <= cnt_d;
            h_q       <= h_d;
            rise_q    <= start_s;
            running_q <= (state_d == RUN) || (state_d == STEP_HI) || (state_d == STEP_LO);
            count_q   <= count_q + {{(COUNT_WIDTH-1){1'b0}}, start_s};
        end
    end

    assign CLOCK       = clock_q;
    assign CLOCK_RISE  = rise_q;
    assign CYCLE_COUNT = count_q;
    assign RUNNING     = running_q;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// Randomised bench for cpu_clock_gen against a period-timeline reference model.
module tb_cpu_clock_gen;

    localparam int HZ  = 16;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sel;
    logic [1:0]  mode;
    logic        button;
    logic        clock_o, rise_o, running_o;
    logic [31:0] count_o;
    logic        clock4, rise4, running4;
    logic [3:0]  count4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cpu_clock_gen #(.CLOCK_HZ(HZ), .SEL_WIDTH(4), .DEBOUNCE_CYCLES(DEB), .COUNT_WIDTH(32)) dut (
        .PHYSICAL_CLOCK(clk), .PHYSICAL_RESET(rst_n), .SEL(sel), .MODE(mode), .BUTTON(button),
        .CLOCK(clock_o), .CLOCK_RISE(rise_o), .CYCLE_COUNT(count_o), .RUNNING(running_o));

    cpu_clock_gen #(.CLOCK_HZ(HZ), .SEL_WIDTH(4), .DEBOUNCE_CYCLES(DEB), .COUNT_WIDTH(4)) dut4 (
        .PHYSICAL_CLOCK(clk), .PHYSICAL_RESET(rst_n), .SEL(sel), .MODE(mode), .BUTTON(button),
        .CLOCK(clock4), .CLOCK_RISE(rise4), .CYCLE_COUNT(count4), .RUNNING(running4));

    // Reference model: where the generator is (0 halted, 1 armed for a step,
    // 2 inside a run period, 3 inside a step period), cycles since the period
    // began and its half length; the button filter is a sliding window.
    int          m_where;
    int          m_e;
    int          m_h;
    logic [31:0] m_count;
    logic        m_clk, m_rise, m_running;
    bit          m_level, m_pend, m_press_now, m_flip;
    int          m_start_kind;
    bit          hist[$];

    function automatic int half_of(int s);
        int h;
        h = HZ / (1 << (s + 1));
        return (h == 0) ? 1 : h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_where = 0; m_e = 0; m_h = half_of(0); m_count = 0;
            m_clk = 0; m_rise = 0; m_running = 0; m_level = 0; m_pend = 0;
            hist = {};
            repeat (DEB + 2) hist.push_back(1'b0);
        end else begin
            // button: accepted level changes when the DEB synchronised samples all disagree
            m_press_now = m_pend;
            m_flip = 1;
            for (int i = 0; i < DEB; i++)
                if (hist[hist.size() - 2 - i] == m_level) m_flip = 0;
            m_pend = 0;
            if (m_flip) begin
                m_level = ~m_level;
                m_pend  = m_level;
            end
            hist.push_back(button);
            if (hist.size() > DEB + 2) void'(hist.pop_front());
            // clock timeline
            m_start_kind = 0;
            m_rise = 0;
            if (m_where >= 2) begin
                m_e++;
                if (m_e == 2 * m_h) begin
                    if (m_where == 3) m_where = 1;
                    else if (mode == 2'd1) m_start_kind = 2;
                    else if (mode == 2'd2) m_where = 1;
                    else m_where = 0;
                end
            end else if (m_where == 1) begin
                if (m_press_now) m_start_kind = 3;
                else if (mode == 2'd1) m_start_kind = 2;
                else if (mode != 2'd2) m_where = 0;
            end else begin
                if (mode == 2'd1) m_start_kind = 2;
                else if (mode == 2'd2) m_where = 1;
            end
            if (m_start_kind != 0) begin
                m_where = m_start_kind;
                m_e = 0;
                m_h = half_of(int'(sel));
                m_count = m_count + 1;
                m_rise = 1;
            end
            m_clk = (m_where >= 2) && (m_e < m_h);
            m_running = (m_where >= 2);
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'd1; sel = 4'd0; button = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({clock_o, rise_o, running_o, count_o, clock4, rise4, running4, count4} !== 41'd0)
            $display("FAIL reset clk=%b rise=%b run=%b count=%0d count4=%0d required all 0",
                     clock_o, rise_o, running_o, count_o, count4);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_run_basic();
        @(negedge clk);
        total++;
        if (clock_o !== 1'b1 || count_o !== 32'd1)
            $display("FAIL first_edge clk=%b count=%0d required 1 and 1", clock_o, count_o);
        else passed++;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            total++;
            if ({clock_o, rise_o, running_o, count_o} !== {m_clk, m_rise, m_running, m_count})
                $display("FAIL run_basic t=%0t clk=%b/%b rise=%b/%b run=%b/%b count=%0d/%0d (actual/required)",
                         $time, clock_o, m_clk, rise_o, m_rise, running_o, m_running, count_o, m_count);
            else passed++;
        end
    endtask

    task automatic test_rate_change();
        mode = 2'd1;
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 9) == 0) sel = 4'($urandom_range(0, 5));
            @(negedge clk);
            total++;
            if ({clock_o, rise_o, running_o, count_o} !== {m_clk, m_rise, m_running, m_count})
                $display("FAIL rate_change t=%0t sel=%0d clk=%b/%b rise=%b/%b count=%0d/%0d (actual/required)",
                         $time, sel, clock_o, m_clk, rise_o, m_rise, count_o, m_count);
            else passed++;
        end
    endtask

    task automatic test_halt();
        int guard;
        mode = 2'd1; sel = 4'd0;
        guard = 0;
        while (!(m_running && !m_clk) && guard < 100) begin @(negedge clk); guard++; end
        total++;
        if (guard >= 100) $display("FAIL halt_wait low phase never reached"); else passed++;
        repeat (2) @(negedge clk);
        mode = 2'd0;
        for (int c = 0; c < 340; c++) begin
            if (c > 40 && $urandom_range(0, 11) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) sel = 4'($urandom_range(0, 4));
            @(negedge clk);
            total++;
            if ({clock_o, rise_o, running_o, count_o} !== {m_clk, m_rise, m_running, m_count})
                $display("FAIL halt t=%0t mode=%0d clk=%b/%b rise=%b/%b run=%b/%b count=%0d/%0d (actual/required)",
                         $time, mode, clock_o, m_clk, rise_o, m_rise, running_o, m_running, count_o, m_count);
            else passed++;
        end
    endtask

    task automatic test_step();
        bit q[$];
        int n;
        mode = 2'd2; sel = 4'd2;
        q = {1'b1, 1'b0, 1'b1};
        repeat (12) q.push_back(1'b1);
        repeat (20) q.push_back(1'b0);
        for (int p = 0; p < 12; p++) begin
            n = $urandom_range(0, 3);
            for (int b = 0; b < n; b++) begin
                repeat ($urandom_range(1, 2)) q.push_back(1'b1);
                repeat ($urandom_range(1, 2)) q.push_back(1'b0);
            end
            repeat ($urandom_range(2, 20)) q.push_back(1'b1);
            repeat ($urandom_range(1, 3)) begin q.push_back(1'b0); q.push_back(1'b1); end
            repeat ($urandom_range(3, 40)) q.push_back(1'b0);
        end
        foreach (q[i]) begin
            if (i > 40 && $urandom_range(0, 15) == 0) sel = 4'($urandom_range(0, 3));
            button = q[i];
            @(negedge clk);
            total++;
            if ({clock_o, rise_o, running_o, count_o} !== {m_clk, m_rise, m_running, m_count})
                $display("FAIL step t=%0t btn=%b clk=%b/%b rise=%b/%b run=%b/%b count=%0d/%0d (actual/required)",
                         $time, button, clock_o, m_clk, rise_o, m_rise, running_o, m_running, count_o, m_count);
            else passed++;
        end
        button = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) button = ~button;
            @(negedge clk);
            total++;
            if ({clock_o, rise_o, running_o, count_o, clock4, rise4, running4, count4} !==
                {m_clk, m_rise, m_running, m_count, m_clk, m_rise, m_running, m_count[3:0]})
                $display("FAIL random t=%0t clk=%b/%b rise=%b/%b run=%b/%b count=%0d/%0d count4=%0d (actual/required)",
                         $time, clock_o, m_clk, rise_o, m_rise, running_o, m_running, count_o, m_count, count4);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        bit seen_wrap;
        logic [3:0] prev;
        seen_wrap = 0;
        mode = 2'd1; sel = 4'd4; button = 1'b0;
        prev = count4;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (prev == 4'd15 && count4 == 4'd0) seen_wrap = 1;
            prev = count4;
            total++;
            if ({clock4, rise4, running4, count4} !== {m_clk, m_rise, m_running, m_count[3:0]})
                $display("FAIL wrap t=%0t clk=%b/%b rise=%b/%b count4=%0d/%0d (actual/required)",
                         $time, clock4, m_clk, rise4, m_rise, count4, m_count[3:0]);
            else passed++;
        end
        total++;
        if (seen_wrap !== 1'b1) $display("FAIL wrap_seen saw=%b required 1", seen_wrap); else passed++;
    endtask

    task automatic test_reset_mid();
        int guard;
        mode = 2'd1; sel = 4'd0;
        guard = 0;
        while (!(m_clk && m_running) && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        total++;
        if (guard >= 100 || clock_o !== 1'b1 || count_o == 32'd0)
            $display("FAIL reset_mid_pre clk=%b count=%0d required 1 and nonzero", clock_o, count_o);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (clock_o !== 1'b0 || count_o !== 32'd0 || running_o !== 1'b0 || clock4 !== 1'b0 || count4 !== 4'd0)
            $display("FAIL reset_mid clk=%b count=%0d run=%b count4=%0d required 0", clock_o, count_o, running_o, count4);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            total++;
            if ({clock_o, rise_o, running_o, count_o} !== {m_clk, m_rise, m_running, m_count})
                $display("FAIL after_reset t=%0t clk=%b/%b rise=%b/%b count=%0d/%0d (actual/required)",
                         $time, clock_o, m_clk, rise_o, m_rise, count_o, m_count);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_run_basic();
        test_rate_change();
        test_halt();
        test_step();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
